// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Types and default constants shared by the CNN datapath blocks: the image
// loader and the conv/pool stages that read its buffer.
//   pixel_t         one pixel word
//   loader_state_e  image loader control states
//   DATA_W          bits per pixel word
//   BLOCK_WORDS     words delivered per memory response
//   BUF_DEPTH       image buffer depth in words
// ----------------------------------------------------------------------------
package cnn_pkg;

   localparam int DATA_W      = 16;
   localparam int BLOCK_WORDS = 150;
   localparam int BUF_DEPTH   = 1024;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } loader_state_e;

endpackage

// File: rtl/image_block_loader_buffer.sv
// ----------------------------------------------------------------------------
// loader_buffer
// BUF_DEPTH x DATA_W image storage. One memory block of BLOCK_WORDS words is
// written per cycle starting at wr_base; only words whose address is below
// wr_limit are stored, the rest of the block is dropped. One registered read
// port with a single cycle of latency; a read of a word written in the same
// cycle returns the old contents.
//   clk, rst   clock, asynchronous active-high reset (read register only)
//   we         write strobe for the whole block
//   wr_base    buffer address of word 0 of the block
//   wr_limit   first address not to be written (image word total)
//   wr_data    block data, word 0 in the LSBs
//   rd_addr    read address; addresses >= BUF_DEPTH read as zero
//   rd_data    registered read data
// ----------------------------------------------------------------------------
module loader_buffer
   import cnn_pkg::*;
#(
   parameter int DATA_W      = cnn_pkg::DATA_W,
   parameter int BLOCK_WORDS = cnn_pkg::BLOCK_WORDS,
   parameter int BUF_DEPTH   = cnn_pkg::BUF_DEPTH,
   parameter int BUF_AW      = 10,
   parameter int WC_W        = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [WC_W-1:0]               wr_base,
   input  logic [WC_W-1:0]               wr_limit,
   input  logic [BLOCK_WORDS*DATA_W-1:0] wr_data,
   input  logic [BUF_AW-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data
);

   logic [DATA_W-1:0] mem [BUF_DEPTH];

   logic              wr_en  [BLOCK_WORDS];
   logic [BUF_AW-1:0] wr_idx [BLOCK_WORDS];

   // Per-word enable masks off the tail of the last, partial block.
   always_comb begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
         wr_en[k]  = we && ((wr_base + WC_W'(k)) < wr_limit);
         wr_idx[k] = BUF_AW'(wr_base + WC_W'(k));
      end
   end

   // Storage is deliberately not reset: contents survive an aborted load.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
         if (wr_en[k]) begin
            mem[wr_idx[k]] <= wr_data[k*DATA_W +: DATA_W];
         end
      end
   end

   generate
      if (BUF_DEPTH < (1 << BUF_AW)) begin : g_rd_guard
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data <= '0;
            end else if (int'(rd_addr) < BUF_DEPTH) begin
               rd_data <= mem[rd_addr];
            end else begin
               rd_data <= '0;
            end
         end
      end else begin : g_rd_full
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data <= '0;
            end else begin
               rd_data <= mem[rd_addr];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/image_block_loader.sv
// ----------------------------------------------------------------------------
// image_block_loader
// Fetches an img_size x img_size x num_ch image from external memory in
// BLOCK_WORDS-word bursts and packs the bursts contiguously into loader_buffer.
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle load request, honoured only in IDLE
//   img_size    image side length, latched on start
//   num_ch      channel count, latched on start
//   base_addr   first memory word address, latched on start
//   mem_req     request outstanding, held until mem_valid
//   mem_addr    memory address of the current block
//   mem_valid   response strobe, mem_data valid this cycle
//   mem_data    block data, word 0 in the LSBs
//   busy        load in progress
//   done        one-cycle completion pulse
//   err         image larger than buffer; valid with done, held until start
//   rd_addr     buffer read address
//   rd_data     buffer read data, one cycle latency
// ----------------------------------------------------------------------------
module image_block_loader
   import cnn_pkg::*;
#(
   parameter int DATA_W      = cnn_pkg::DATA_W,
   parameter int BLOCK_WORDS = cnn_pkg::BLOCK_WORDS,
   parameter int IMG_W       = 6,
   parameter int CH_W        = 2,
   parameter int BUF_DEPTH   = cnn_pkg::BUF_DEPTH,
   parameter int ADDR_W      = 32,
   parameter int BUF_AW      = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [IMG_W-1:0]              img_size,
   input  logic [CH_W-1:0]               num_ch,
   input  logic [ADDR_W-1:0]             base_addr,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_valid,
   input  logic [BLOCK_WORDS*DATA_W-1:0] mem_data,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   input  logic [BUF_AW-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data
);

   // Counter width covers both the full product and the word counter's
   // overshoot past the buffer end on the last block.
   localparam int TOT_W  = 2*IMG_W + CH_W;
   localparam int WC_RAW = $clog2(BUF_DEPTH + BLOCK_WORDS + 1);
   localparam int CNT_W  = ((TOT_W > WC_RAW) ? TOT_W : WC_RAW) + 1;

   loader_state_e    state;
   logic [CNT_W-1:0] wc;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] total_in;
   logic [CNT_W-1:0] wc_next;
   logic             blk_we;

   assign total_in = CNT_W'(img_size) * CNT_W'(img_size) * CNT_W'(num_ch);
   assign wc_next  = wc + CNT_W'(BLOCK_WORDS);
   assign blk_we   = (state == REQ) && mem_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         wc       <= '0;
         total_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  total_q  <= total_in;
                  mem_addr <= base_addr;
                  wc       <= '0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  if (total_in == '0) begin
                     state <= DONE;
                  end else if (total_in > CNT_W'(BUF_DEPTH)) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     mem_req <= 1'b1;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_valid) begin
                  mem_addr <= mem_addr + ADDR_W'(BLOCK_WORDS);
                  wc       <= wc_next;
                  if (wc_next >= total_q) begin
                     mem_req <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   loader_buffer #(
      .DATA_W      (DATA_W),
      .BLOCK_WORDS (BLOCK_WORDS),
      .BUF_DEPTH   (BUF_DEPTH),
      .BUF_AW      (BUF_AW),
      .WC_W        (CNT_W)
   ) u_buffer (
      .clk      (clk),
      .rst      (rst),
      .we       (blk_we),
      .wr_base  (wc),
      .wr_limit (total_q),
      .wr_data  (mem_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

endmodule

// File: doc/image_block_loader.md
Name: image_block_loader

Overview:
Parametrised image loader for the CNN datapath. On `start` it fetches a `img_size` x `img_size` x `num_ch` image from external memory in fixed `BLOCK_WORDS`-word bursts over a req/valid handshake, and packs the bursts contiguously into an internal buffer. Downstream conv/pool stages read that buffer through a registered read port. It adds reset, a start/busy/done handshake, memory back-pressure, channel count, partial last-block masking and overflow detection.

Parameters:
DATA_W, 16, bits per pixel word
BLOCK_WORDS, 150, words delivered per memory response
IMG_W, 6, width of img_size (max side 63)
CH_W, 2, width of num_ch (1..3 channels used)
BUF_DEPTH, 1024, buffer depth in words
ADDR_W, 32, memory word-address width
BUF_AW, 10, buffer address width, equal to clog2(BUF_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
img_size  in  IMG_W  image side length; latched on start
num_ch  in  CH_W  channel count; latched on start
base_addr  in  ADDR_W  first memory word address; latched on start
mem_req  out  1  request outstanding, held until mem_valid
mem_addr  out  ADDR_W  address of the current block
mem_valid  in  1  response strobe; mem_data valid this cycle
mem_data  in  BLOCK_WORDS*DATA_W  block data, word 0 in the LSBs
busy  out  1  high from IDLE exit until DONE
done  out  1  one-cycle completion pulse
err  out  1  overflow flag, valid with done, held until next start
rd_addr  in  BUF_AW  buffer read address
rd_data  out  DATA_W  buffer word, one-cycle latency

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req, busy, done and err = 0.
  - mem_addr = 0, rd_data = 0, internal word counter = 0.
  - Buffer contents are not cleared.
- total = img_size*img_size*num_ch, computed at width 2*IMG_W+CH_W on the latched values. No divider; block count comes from the running word counter wc.
- IDLE:
  - On start: latch inputs, set mem_addr = base_addr, wc = 0, err = 0.
  - If total == 0, go to DONE.
  - Else if total > BUF_DEPTH, set err = 1 and go to DONE.
  - Else go to REQ.
  - busy asserts the cycle after start.
- REQ:
  - mem_req = 1; mem_addr holds stable while mem_valid is low (unbounded stall allowed).
  - On mem_valid: write word k to buf[wc+k] for every k with wc+k < total. Words past total are discarded; the buffer beyond total is untouched.
  - Same edge: mem_addr += BLOCK_WORDS, wc += BLOCK_WORDS.
  - If wc+BLOCK_WORDS >= total, drop mem_req and go to DONE; else stay in REQ with mem_req kept high (back-to-back blocks allowed).
- DONE: done = 1 and busy = 0 for one cycle, then IDLE.
- mem_valid outside REQ is ignored.
- start outside IDLE is ignored, including in the DONE cycle.
- Read port: rd_data <= buf[rd_addr] every cycle, independent of state.
  - A read of a word written the same cycle returns the old value.
  - rd_addr >= BUF_DEPTH returns 0.
- Latency: blocks = ceil(total/BLOCK_WORDS). With mem_valid high every cycle, done pulses at start+blocks+2.
- Reset asserted mid-load aborts immediately to IDLE with mem_req low. Words already written stay in the buffer.

Decomposition:
- Shared package cnn_pkg holds:
  - the pixel_t typedef (logic [DATA_W-1:0]);
  - the loader_state_e enum {IDLE, REQ, DONE};
  - default constants DATA_W, BLOCK_WORDS and BUF_DEPTH, shared with the conv stages.
- One sub-module, loader_buffer: BUF_DEPTH x DATA_W storage with a BLOCK_WORDS-wide masked write and one registered read port.
- The FSM, address logic and counters stay in the top.

Test Plan:
- img_size=32, num_ch=1, base_addr=0x1000, mem_valid every cycle -> 7 requests at mem_addr 0x1000, 0x1096, …, 0x1384; last block writes 124 words; done at start+9; err=0; rd_addr 0..1023 returns the expected data.
- img_size=10, num_ch=1 -> total 100, one request; buf[100..149] unchanged (pre-filled pattern); done at start+3.
- img_size=20, num_ch=3 (total 1200) -> no mem_req, err=1 with done; a repeat with img_size=0 -> done at start+2 with err=0.
- img_size=16, num_ch=2, mem_valid delayed 5 cycles per block -> mem_addr stable throughout each stall; 4 blocks (512 words) loaded; busy high until done.
- Reset pulsed during the third block of img_size=32 -> mem_req, busy and done go low asynchronously; a fresh start then completes normally.
- start pulsed while busy, and mem_valid pulsed in IDLE -> both ignored; no extra writes or address change.
